// File: rtl/serial_wide_adder.sv
// serial_wide_adder: K*W-bit adder that processes one W-bit word per cycle, LSW first
module carry_bypass_adder #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  if (W % N != 0) begin : g_bad_n
    $error("carry_bypass_adder: W must be a multiple of N");
  end
  logic c, cb;
  // ripple inside each N-bit block; a fully-propagating block forwards its carry-in directly
  always_comb begin
    c = cin;
    cb = cin;
    sum = '0;
    for (int j = 0; j < W / N; j++) begin
      cb = c;
      for (int i = 0; i < N; i++) begin
        sum[j*N+i] = a[j*N+i] ^ b[j*N+i] ^ c;
        c = (a[j*N+i] & b[j*N+i]) | ((a[j*N+i] ^ b[j*N+i]) & c);
      end
      c = &(a[j*N+:N] ^ b[j*N+:N]) ? cb : c;
    end
    cout = c;
  end
endmodule

module serial_wide_adder #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*W-1:0] a,
  input  logic [K*W-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [K*W-1:0] sum,
  output logic           cout,
  output logic           ovf
);
  if (K < 1) begin : g_bad_k
    $error("serial_wide_adder: K must be at least 1");
  end
  localparam int CW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [K*W-1:0] a_r, b_r;
  logic carry, co, last;
  logic [W-1:0] s;
  assign last = cnt == CW'(K - 1);
  carry_bypass_adder #(.W(W), .N(N)) u_add (
    .a(a_r[cnt*W+:W]),
    .b(b_r[cnt*W+:W]),
    .cin(carry),
    .sum(s),
    .cout(co)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // accept in IDLE, walk K words in RUN, hold the result in DONE until taken
  always_comb begin
    state_n = (state == IDLE && in_valid) ? RUN :
              (state == RUN && last)      ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  // handshake outputs decoded from the registered state
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // operand latch, per-word sum write and carry ripple between words
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      carry <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sum[cnt*W+:W] <= s;
      carry <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        cout <= co;
        ovf <= (a_r[K*W-1] == b_r[K*W-1]) && (s[W-1] != a_r[K*W-1]);
      end
    end
  end
endmodule

// File: tb/tb_serial_wide_adder.sv
// tb_serial_wide_adder: directed and randomised checks of the serial wide adder
module tb_serial_wide_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [127:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [127:0] sum;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
  logic [31:0] a1 = '0, b1 = '0;
  logic in_ready1, out_valid1, cout1, ovf1;
  logic [31:0] sum1;
  int vectors = 0;
  int miscompares = 0;
  int lat, accepts, results;
  logic [127:0] x, y;
  logic [128:0] g;
  logic c, eo;

  serial_wide_adder #(.W(32), .N(4), .K(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_wide_adder #(.W(32), .N(4), .K(1)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input logic [127:0] xa, input logic [127:0] xb, input logic xc,
                        input logic [127:0] es, input logic ec, input logic ev, input string tag);
    int n;
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    chk({tag, " ready"}, in_ready, 1);
    step();
    in_valid = 1'b0; a = ~xa; b = ~xb; cin = ~xc;
    wait_out(n);
    chk({tag, " latency"}, n, 4);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " ovf"}, ovf, ev);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " drop"}, out_valid, 0);
    chk({tag, " idle"}, in_ready, 1);
  endtask

  task automatic run_k1(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                        input logic [31:0] es, input logic ec, input logic ev, input string tag);
    int n;
    in_valid1 = 1'b1; a1 = xa; b1 = xb; cin1 = xc;
    step();
    in_valid1 = 1'b0; a1 = ~xa; b1 = ~xb;
    n = 0;
    while (!out_valid1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, n, 1);
    chk({tag, " sum"}, sum1, es);
    chk({tag, " cout"}, cout1, ec);
    chk({tag, " ovf"}, ovf1, ev);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk({tag, " drop"}, out_valid1, 0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);

    run_op({128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, "wrap");
    run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1, "posovf");
    run_op(128'd0, 128'd0, 1'b1, 128'd1, 1'b0, 1'b0, "cin");
    run_op({1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 128'd0, 1'b1, 1'b1, "negovf");
    run_op({128{1'b1}}, {128{1'b1}}, 1'b0, {{127{1'b1}}, 1'b0}, 1'b1, 1'b0, "minus2");
    run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
           128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0, "ripple3");
    run_op(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'h11111111_11111111_11111111_11111111, 1'b1,
           128'h23456789_ABCDF001_20FEDCBA_98765433, 1'b0, 1'b0, "mixed");

    in_valid = 1'b1; a = 128'd1; b = 128'd2; cin = 1'b0;
    step();
    a = 128'd5; b = 128'd6;
    wait_out(lat);
    chk("hold latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
      chk("hold sum", sum, 3);
      chk("hold cout", cout, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release out_valid", out_valid, 0);
    chk("release in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("second latency", lat, 4);
    chk("second sum", sum, 11);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    in_valid = 1'b1; a = {4{32'h5}}; b = 128'd0; cin = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    repeat (5) step();
    chk("abort quiet", out_valid, 0);
    run_op({128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0, "after abort");

    accepts = 0;
    results = 0;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      y = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = 1'($urandom_range(0, 1));
      g = {1'b0, x} + {1'b0, y} + {128'd0, c};
      eo = (x[127] == y[127]) && (g[127] != x[127]);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      in_valid = 1'b1; a = x; b = y; cin = c;
      if (in_ready) accepts++;
      step();
      in_valid = 1'b0;
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      lat = 0;
      while (!out_valid && lat < 20) begin
        in_valid = 1'($urandom_range(0, 1));
        if (in_valid && in_ready) accepts++;
        step();
        lat++;
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        if (in_valid && in_ready) accepts++;
        step();
      end
      chk("rand valid", out_valid, 1);
      chk("rand sum", sum, g[127:0]);
      chk("rand cout", cout, g[128]);
      chk("rand ovf", ovf, eo);
      out_ready = 1'b1;
      if (out_valid) results++;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
    end
    chk("accept count", accepts, 1000);
    chk("result count", results, 1000);

    run_k1(32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, "k1 wrap");
    run_k1(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, "k1 ovf");
    run_k1(32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0, 1'b0, "k1 cin");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
